// File: rtl/aes_pkg.sv
// Shared types and word packing helpers for the AES-128 stream adapter.
package aes_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;

    typedef enum logic [1:0] {
        OP_ENC = 2'b00,
        OP_DEC = 2'b01,
        OP_KEY = 2'b10,
        OP_ILL = 2'b11
    } aes_op_t;

    typedef enum logic [1:0] {
        COLLECT   = 2'b00,
        ISSUE     = 2'b01,
        WAIT_DONE = 2'b10,
        GAP       = 2'b11
    } adp_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
    } m_beat_t;

    // Words 0..2 sit in w012 little-end first; w3 is the word arriving now.
    function automatic logic [BLK_W-1:0] pack_block(input logic [95:0]       w012,
                                                    input logic [WORD_W-1:0] w3,
                                                    input logic              msb_first);
        if (msb_first) begin
            return {w012[31:0], w012[63:32], w012[95:64], w3};
        end
        return {w3, w012[95:64], w012[63:32], w012[31:0]};
    endfunction

    function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                   input logic [1:0]       idx,
                                                   input logic             msb_first);
        logic [1:0] pos;
        pos = msb_first ? 2'(2'd3 - idx) : idx;
        case (pos)
            2'd0:    return blk[31:0];
            2'd1:    return blk[63:32];
            2'd2:    return blk[95:64];
            default: return blk[127:96];
        endcase
    endfunction

endpackage

// File: rtl/aes128_word_unpack.sv
// Holds one 128-bit core result and replays it as four 32-bit valid/ready beats.
module aes128_word_unpack
    import aes_pkg::*;
#(
    parameter bit WORD_MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cap_i,
    input  logic [BLK_W-1:0]    cap_data_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [WORD_W-1:0]   data_o,
    output logic                last_o
);

    logic [BLK_W-1:0] buf_q;
    logic             full_q;
    logic [1:0]       rcnt_q;
    logic [1:0]       rcnt_d;
    m_beat_t          beat_q;

    assign rcnt_d = rcnt_q + 2'd1;

    // A capture always wins over the final drain beat in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            full_q <= 1'b0;
            rcnt_q <= '0;
            beat_q <= '0;
        end else if (cap_i) begin
            buf_q  <= cap_data_i;
            full_q <= 1'b1;
            rcnt_q <= '0;
            beat_q <= '{data: word_sel(cap_data_i, 2'd0, WORD_MSB_FIRST), last: 1'b0};
        end else if (full_q && ready_i) begin
            if (rcnt_q == 2'd3) begin
                full_q <= 1'b0;
                rcnt_q <= '0;
                beat_q <= '0;
            end else begin
                rcnt_q <= rcnt_d;
                beat_q <= '{data: word_sel(buf_q, rcnt_d, WORD_MSB_FIRST),
                            last: (rcnt_d == 2'd3)};
            end
        end
    end

    assign valid_o = full_q;
    assign data_o  = beat_q.data;
    assign last_o  = beat_q.last;

endmodule

// File: rtl/aes128_stream_adapter.sv
// Word-stream front end for an AES-128 core: packs input blocks, issues key-load /
// encrypt / decrypt strobes with a done watchdog, and streams results back out.
module aes128_stream_adapter
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          WORD_MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [31:0]   s_data_i,
    input  logic [1:0]    s_op_i,
    output logic          core_load_key_o,
    output logic          core_start_enc_o,
    output logic          core_start_dec_o,
    output logic [127:0]  core_data_o,
    input  logic          core_ready_i,
    input  logic          core_done_i,
    input  logic [127:0]  core_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [31:0]   m_data_o,
    output logic          m_last_o,
    output logic          key_valid_o,
    output logic          err_o,
    input  logic          err_clr_i
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    adp_state_t      state_q;
    logic [1:0]      wcnt_q;
    logic [95:0]     asm_q;
    aes_op_t         op_q;
    aes_op_t         pend_op_q;
    logic            pending_q;
    logic            pending_d;
    logic [BLK_W-1:0] blk_q;
    logic            key_valid_q;
    logic            err_q;
    logic            ld_q;
    logic            enc_q;
    logic            dec_q;
    logic [WD_W-1:0] wd_q;

    logic s_hs_c;
    logic blk_bad_c;
    logic can_issue_c;
    logic cap_c;
    logic timeout_c;
    logic err_set_c;

    // The last word of a new block may not overwrite blk_q while the core still uses it.
    assign s_ready_o = !pending_q && !((wcnt_q == 2'd3) && (state_q != COLLECT));
    assign s_hs_c    = s_valid_i && s_ready_o;

    assign blk_bad_c = (state_q == COLLECT) && pending_q &&
                       ((pend_op_q == OP_ILL) || ((pend_op_q != OP_KEY) && !key_valid_q));

    assign can_issue_c = (state_q == COLLECT) && pending_q && !blk_bad_c && core_ready_i &&
                         ((pend_op_q == OP_KEY) || !m_valid_o);

    assign cap_c     = (state_q == WAIT_DONE) && core_done_i;
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (state_q == WAIT_DONE) && !core_done_i &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign err_set_c = blk_bad_c || timeout_c;

    always_comb begin
        pending_d = pending_q;
        if (blk_bad_c || (state_q == ISSUE)) begin
            pending_d = 1'b0;
        end
        if (s_hs_c && (wcnt_q == 2'd3)) begin
            pending_d = 1'b1;
        end
    end

    // Input packing: op rides with word 0, block and op move to the pending register on word 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            asm_q     <= '0;
            op_q      <= OP_ENC;
            pend_op_q <= OP_ENC;
            blk_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (s_hs_c) begin
                wcnt_q <= wcnt_q + 2'd1;
                case (wcnt_q)
                    2'd0: begin
                        asm_q[31:0] <= s_data_i;
                        op_q        <= aes_op_t'(s_op_i);
                    end
                    2'd1:    asm_q[63:32] <= s_data_i;
                    2'd2:    asm_q[95:64] <= s_data_i;
                    default: begin
                        blk_q     <= pack_block(asm_q, s_data_i, WORD_MSB_FIRST);
                        pend_op_q <= op_q;
                    end
                endcase
            end
        end
    end

    // Issue FSM with registered strobes, key flag, sticky error and done watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            ld_q        <= 1'b0;
            enc_q       <= 1'b0;
            dec_q       <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            ld_q  <= 1'b0;
            enc_q <= 1'b0;
            dec_q <= 1'b0;
            if (err_set_c) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
            case (state_q)
                COLLECT: begin
                    if (can_issue_c) begin
                        state_q <= ISSUE;
                        ld_q    <= (pend_op_q == OP_KEY);
                        enc_q   <= (pend_op_q == OP_ENC);
                        dec_q   <= (pend_op_q == OP_DEC);
                    end
                end
                ISSUE: begin
                    wd_q <= '0;
                    if (pend_op_q == OP_KEY) begin
                        state_q     <= GAP;
                        key_valid_q <= 1'b1;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (core_done_i || timeout_c) begin
                        state_q <= COLLECT;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                GAP:     state_q <= COLLECT;
                default: state_q <= COLLECT;
            endcase
        end
    end

    aes128_word_unpack #(
        .WORD_MSB_FIRST (WORD_MSB_FIRST)
    ) u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_i      (cap_c),
        .cap_data_i (core_data_i),
        .ready_i    (m_ready_i),
        .valid_o    (m_valid_o),
        .data_o     (m_data_o),
        .last_o     (m_last_o)
    );

    assign core_load_key_o  = ld_q;
    assign core_start_enc_o = enc_q;
    assign core_start_dec_o = dec_q;
    assign core_data_o      = blk_q;
    assign key_valid_o      = key_valid_q;
    assign err_o            = err_q;

endmodule
